// File: rtl/event_fifo_arbiter.sv
// event_fifo_arbiter
// Shares one event FIFO write port among NUM_REQ spike-event producers.
// Ownership passes round-robin. A granted producer keeps the port for up to
// MAX_BURST consecutive writes, and then the next requester gets the port.
// Every accepted payload is tagged with its source index before it is written.
//
// Ports:
//   clk              system clock; all state changes on the rising edge
//   rst_n            asynchronous active-low reset
//   enable           arbitration enable; when low, all state holds
//   req_valid        per-requester event valid
//   req_data         packed payloads; requester i is at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        per-requester accept; at most one bit is high
//   fifo_full        full flag from the downstream FIFO
//   fifo_write_en    FIFO write strobe (combinational, same-cycle)
//   fifo_write_data  {source_id, payload} on a write, 0 otherwise
//   grant_id         current owner in BURST, last owner in IDLE
//   busy             high while in BURST
//   accept_count     total accepted events, saturating at 16'hFFFF
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick the first valid requester from rr_ptr (wrapping)
// BURST | owner holds the port until MAX_BURST writes or owner drops valid

module event_fifo_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_write_en,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_write_data,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy,
  output logic [15:0]                    accept_count
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [15:0]         accept_count_q;

  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] src;
  logic                xfer;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] x);
    if (int'(x) == NUM_REQ - 1) begin
      return '0;
    end
    return x + ID_WIDTH'(1);
  endfunction

  // Rotating priority search: the first valid requester at or above rr_ptr,
  // wrapping past NUM_REQ-1 back to 0.
  always_comb begin : sel_search
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        sel   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      burst_cnt_q    <= '0;
      accept_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      if (xfer && (accept_count_q != 16'hFFFF)) begin
        accept_count_q <= accept_count_q + 16'd1;
      end
    end
  end

  // Next-state logic. When enable is low, xfer is 0 and the BURST branch is
  // gated, so every register holds its value.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          owner_d = sel;
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_id(sel);
          end else begin
            state_d     = S_BURST;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      S_BURST: begin
        if (enable) begin
          if (!req_valid[owner_q]) begin
            // The owner ran dry. Give up the port; this cycle is a bubble.
            state_d  = S_IDLE;
            rr_ptr_d = next_id(owner_q);
          end else if (xfer) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            if (int'(burst_cnt_q) + 1 == MAX_BURST) begin
              state_d  = S_IDLE;
              rr_ptr_d = next_id(owner_q);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. req_ready is gated with rst_n so that it drops as soon as reset
  // is asserted, even while requesters are still presenting valid.
  always_comb begin
    req_ready = '0;
    if (rst_n && enable && !fifo_full) begin
      if (state_q == S_IDLE) begin
        if (|req_valid) begin
          req_ready[sel] = 1'b1;
        end
      end else begin
        if (req_valid[owner_q]) begin
          req_ready[owner_q] = 1'b1;
        end
      end
    end
    src             = (state_q == S_BURST) ? owner_q : sel;
    xfer            = |(req_ready & req_valid);
    fifo_write_en   = xfer;
    fifo_write_data = '0;
    if (xfer) begin
      fifo_write_data = {src, req_data[int'(src)*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  assign grant_id     = owner_q;
  assign busy         = (state_q == S_BURST);
  assign accept_count = accept_count_q;

endmodule

// File: tb/tb_event_fifo_arbiter.sv
module tb_event_fifo_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               fifo_full;
  logic               fifo_write_en;
  logic [DW+IW-1:0]   fifo_write_data;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic [15:0]        accept_count;

  logic [DW-1:0]      pq[NR][$];
  logic [DW+IW-1:0]   exp_q[$];
  int                 n_checks = 0;
  int                 n_fail = 0;

  event_fifo_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data), .grant_id(grant_id),
    .busy(busy), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (pq[i].size() != 0);
      req_data[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : '0;
    end
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  // One clock: capture which requester is accepted, then after the edge
  // retire that producer's payload and present the next one.
  task automatic step();
    logic [NR-1:0] acc;
    logic [DW-1:0] dummy;
    @(negedge clk);
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) dummy = pq[i].pop_front();
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) pq[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic [DW+IW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        check("unexpected_write", 32'(fifo_write_en & (exp_q.size() == 0)), 32'd0);
        if (fifo_write_en && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_data", 32'(fifo_write_data), 32'(e));
          check("ready_one_on_write", 32'($countones(req_ready)), 32'd1);
        end else if (!fifo_write_en) begin
          check("idle_data_zero", 32'(fifo_write_data), 32'd0);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_count", 32'(accept_count), 32'd0);
    check("rst_wen", 32'(fifo_write_en), 32'd0);

    // 1: single requester, burst ends when its valid drops
    do_reset();
    pq[1] = '{8'h11, 8'h12, 8'h13};
    push_exp(1, 8'h11); push_exp(1, 8'h12); push_exp(1, 8'h13);
    drive();
    #1;
    check("t1_ready", 32'(req_ready), 32'b0010);
    step();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd1);
    repeat (3) step();
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_count", 32'(accept_count), 32'd3);
    // rr_ptr must now be 2, so req 3 is granted before req 0
    pq[0] = '{8'h01};
    pq[3] = '{8'h31};
    push_exp(3, 8'h31); push_exp(0, 8'h01);
    drive();
    repeat (5) step();
    check("t1_count2", 32'(accept_count), 32'd5);
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: all requesters valid, blocks of MAX_BURST in order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(i*16 + k));
    for (int k = 0; k < 4; k++) push_exp(0, 8'(8'h00 + k));
    for (int k = 0; k < 4; k++) push_exp(1, 8'(8'h10 + k));
    for (int k = 0; k < 4; k++) push_exp(2, 8'(8'h20 + k));
    for (int k = 0; k < 4; k++) push_exp(3, 8'(8'h30 + k));
    for (int k = 4; k < 8; k++) push_exp(0, 8'(8'h00 + k));
    drive();
    repeat (16) step();
    check("t2_count16", 32'(accept_count), 32'd16);
    repeat (4) step();
    for (int i = 0; i < NR; i++) pq[i].delete();
    drive();
    check("t2_count20", 32'(accept_count), 32'd20);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_grant", 32'(grant_id), 32'd0);
    step();
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: fifo_full stall after 2 writes; burst count must be held
    do_reset();
    pq[0] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    pq[1] = '{8'hB0};
    push_exp(0, 8'hA0); push_exp(0, 8'hA1); push_exp(0, 8'hA2); push_exp(0, 8'hA3);
    push_exp(1, 8'hB0); push_exp(0, 8'hA4); push_exp(0, 8'hA5);
    drive();
    repeat (2) step();
    fifo_full = 1'b1;
    repeat (3) begin
      #1;
      check("t3_ready", 32'(req_ready), 32'd0);
      check("t3_wen", 32'(fifo_write_en), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_grant", 32'(grant_id), 32'd0);
      step();
    end
    fifo_full = 1'b0;
    repeat (10) step();
    check("t3_count", 32'(accept_count), 32'd7);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: owner drops after one write, bubble, req 1 skipped, req 2 granted
    do_reset();
    pq[0] = '{8'h40};
    pq[2] = '{8'h60, 8'h61};
    push_exp(0, 8'h40); push_exp(2, 8'h60); push_exp(2, 8'h61);
    drive();
    repeat (2) step();
    check("t4_bubble_busy", 32'(busy), 32'd0);
    check("t4_bubble_count", 32'(accept_count), 32'd1);
    step();
    check("t4_grant", 32'(grant_id), 32'd2);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_count", 32'(accept_count), 32'd2);
    repeat (3) step();
    check("t4_count_end", 32'(accept_count), 32'd3);
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: async reset in the middle of a req 3 burst
    do_reset();
    pq[3] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    push_exp(3, 8'hD0); push_exp(3, 8'hD1);
    drive();
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 32'd0);
    check("t5_wen", 32'(fifo_write_en), 32'd0);
    check("t5_data", 32'(fifo_write_data), 32'd0);
    check("t5_grant", 32'(grant_id), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_count", 32'(accept_count), 32'd0);
    step();
    rst_n = 1'b1;
    pq[0] = '{8'h50};
    pq[1] = '{8'h51};
    pq[2] = '{8'h52};
    push_exp(0, 8'h50); push_exp(1, 8'h51); push_exp(2, 8'h52);
    push_exp(3, 8'hD2); push_exp(3, 8'hD3);
    drive();
    #1;
    check("t5_first_grant", 32'(req_ready), 32'b0001);
    step();
    check("t5_restart_count", 32'(accept_count), 32'd1);
    check("t5_restart_grant", 32'(grant_id), 32'd0);
    repeat (9) step();
    check("t5_count_end", 32'(accept_count), 32'd5);
    check("t5_drain", 32'(exp_q.size()), 32'd0);

    // 6: enable low for 5 cycles in the middle of a req 2 burst
    do_reset();
    pq[2] = '{8'h70, 8'h71, 8'h72, 8'h73};
    pq[3] = '{8'h80};
    push_exp(2, 8'h70); push_exp(2, 8'h71); push_exp(2, 8'h72); push_exp(2, 8'h73);
    push_exp(3, 8'h80);
    drive();
    repeat (2) step();
    enable = 1'b0;
    repeat (5) begin
      #1;
      check("t6_ready", 32'(req_ready), 32'd0);
      check("t6_wen", 32'(fifo_write_en), 32'd0);
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_grant", 32'(grant_id), 32'd2);
      check("t6_count", 32'(accept_count), 32'd2);
      step();
    end
    enable = 1'b1;
    repeat (8) step();
    check("t6_count_end", 32'(accept_count), 32'd5);
    check("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
